// File: rtl/cu_pkg.sv
// ----------------------------------------------------------------------------
// cu_pkg
// Shared definitions for the multicycle control unit: FSM state type,
// instruction class / operation encodings, immediate-source and ALU-control
// constants, plus a helper that maps an ALU op onto the ALU control word.
// ----------------------------------------------------------------------------
package cu_pkg;

    // Controller sequencing states
    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_EXEC   = 2'b01,
        ST_MEM    = 2'b10,
        ST_BRANCH = 2'b11
    } state_e;

    // Instruction class (tipo)
    localparam logic [1:0] TIPO_ALU = 2'b00;
    localparam logic [1:0] TIPO_MEM = 2'b01;
    localparam logic [1:0] TIPO_BR  = 2'b10;
    localparam logic [1:0] TIPO_NOP = 2'b11;

    // ALU operations
    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_AND = 2'b10;
    localparam logic [1:0] OP_OR  = 2'b11;

    // Memory operation bit positions
    localparam int MEM_STORE_BIT = 0;
    localparam int MEM_ALLCH_BIT = 1;

    // Branch operations
    localparam logic [1:0] BR_B   = 2'b00;
    localparam logic [1:0] BR_BEQ = 2'b01;
    localparam logic [1:0] BR_BL  = 2'b10;
    localparam logic [1:0] BR_RET = 2'b11;

    // Immediate source selector
    localparam logic [1:0] IMM_NONE   = 2'b00;
    localparam logic [1:0] IMM_ALU    = 2'b01;
    localparam logic [1:0] IMM_BRANCH = 2'b10;

    // ALU control words
    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;

    // The ALU control word is the two-bit op with a zero MSB
    function automatic logic [2:0] aluControlFor(input logic [1:0] op);
        return {1'b0, op};
    endfunction

endpackage

// File: rtl/cu_return_stack.sv
// ----------------------------------------------------------------------------
// cu_return_stack
// Return-address storage for BL/RET.
// Configuration macro: CU_RAS_EN
//   defined   : circular stack of RAS_DEPTH entries; a push when full
//               overwrites the oldest entry, a pop when empty returns 0.
//   undefined : single link register; push overwrites it, pop returns it,
//               the store never reports full or empty.
// Ports:
//   clk, rst_n    clock, asynchronous active-low reset
//   push_i        store push_data_i as the newest entry
//   push_data_i   return address to store (PC_W bits)
//   pop_i         discard the newest entry
//   top_o         newest entry (0 when empty)
//   full_o        all RAS_DEPTH entries in use
//   empty_o       no entries in use
// ----------------------------------------------------------------------------
module cu_return_stack #(
    parameter int PC_W      = 9,
    parameter int RAS_DEPTH = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            push_i,
    input  logic [PC_W-1:0] push_data_i,
    input  logic            pop_i,
    output logic [PC_W-1:0] top_o,
    output logic            full_o,
    output logic            empty_o
);

    // Depth must be a power of two so the write pointer wraps naturally
    if (RAS_DEPTH < 2 || (RAS_DEPTH & (RAS_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("cu_return_stack: RAS_DEPTH must be a power of two >= 2");
    end

`ifdef CU_RAS_EN

    localparam int PTR_W = $clog2(RAS_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [PC_W-1:0]  entries_q [RAS_DEPTH];
    logic [PTR_W-1:0] ptr_q;
    logic [CNT_W-1:0] count_q;
    logic [PTR_W-1:0] topIdx;

    // ptr_q is the next slot to write; once full it also points at the
    // oldest entry, so an overflowing push overwrites exactly that one.
    assign topIdx  = ptr_q - PTR_W'(1);
    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == CNT_W'(RAS_DEPTH));
    assign top_o   = empty_o ? '0 : entries_q[topIdx];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q   <= '0;
            count_q <= '0;
            for (int i = 0; i < RAS_DEPTH; i++) begin
                entries_q[i] <= '0;
            end
        end else if (push_i) begin
            entries_q[ptr_q] <= push_data_i;
            ptr_q            <= ptr_q + PTR_W'(1);
            if (!full_o) begin
                count_q <= count_q + CNT_W'(1);
            end
        end else if (pop_i && !empty_o) begin
            ptr_q   <= topIdx;
            count_q <= count_q - CNT_W'(1);
        end
    end

`else

    logic [PC_W-1:0] link_q;

    assign top_o   = link_q;
    assign full_o  = 1'b0;
    assign empty_o = 1'b0;

    // A pop leaves the link register intact; push and pop never coincide
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            link_q <= '0;
        end else if (push_i && !pop_i) begin
            link_q <= push_data_i;
        end
    end

`endif

endmodule

// File: rtl/multicycle_control_unit.sv
// ----------------------------------------------------------------------------
// multicycle_control_unit
// Multicycle controller: accepts a decoded instruction in IDLE, then spends
// one EXEC cycle (ALU/NOP), one BRANCH cycle, or one or more MEM cycles
// (handshaked with mem_ack, optionally stepping through every colour
// channel) before returning to IDLE. BL/RET use a return-address store.
// Configuration macro: CU_RAS_EN (see cu_return_stack); when undefined a
// single link register is used and ras_overflow/ras_underflow stay 0.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   instr_valid/ready   instruction handshake (ready only in IDLE)
//   tipo, op, inm       instruction class, operation, immediate select
//   zero_flag           ALU zero flag for BEQ
//   pc_plus1            link address pushed by BL
//   mem_req/mem_ack     memory request and single-cycle completion
//   reg_write, alu_src, mem_write, result_src, pc_src, imm_src,
//   alu_control         datapath control
//   chan_sel            colour channel of the current memory access
//   pc_return(_valid)   return address produced by RET
//   ras_overflow/underflow  sticky return-stack error flags
// ----------------------------------------------------------------------------
module multicycle_control_unit
    import cu_pkg::*;
#(
    parameter  int PC_W      = 9,
    parameter  int NUM_CH    = 3,
    parameter  int RAS_DEPTH = 4,
    localparam int CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            instr_valid,
    output logic            instr_ready,
    input  logic [1:0]      tipo,
    input  logic [1:0]      op,
    input  logic            inm,
    input  logic            zero_flag,
    input  logic [PC_W-1:0] pc_plus1,
    output logic            mem_req,
    input  logic            mem_ack,
    output logic            reg_write,
    output logic            alu_src,
    output logic            mem_write,
    output logic            result_src,
    output logic            pc_src,
    output logic [1:0]      imm_src,
    output logic [2:0]      alu_control,
    output logic [CH_W-1:0] chan_sel,
    output logic [PC_W-1:0] pc_return,
    output logic            pc_return_valid,
    output logic            ras_overflow,
    output logic            ras_underflow
);

    localparam logic [CH_W-1:0] LAST_CH = CH_W'(NUM_CH - 1);

    state_e          state_q, state_d;
    logic [1:0]      tipo_q, op_q;
    logic            inm_q;
    logic [CH_W-1:0] chan_q, chan_d;
    logic            ovf_q, unf_q;

    logic            accept;
    logic            rasPush, rasPop;
    logic [PC_W-1:0] rasTop;
    logic            rasFull, rasEmpty;

    assign accept = (state_q == ST_IDLE) && instr_valid;

    cu_return_stack #(
        .PC_W      (PC_W),
        .RAS_DEPTH (RAS_DEPTH)
    ) u_ras (
        .clk         (clk),
        .rst_n       (rst_n),
        .push_i      (rasPush),
        .push_data_i (pc_plus1),
        .pop_i       (rasPop),
        .top_o       (rasTop),
        .full_o      (rasFull),
        .empty_o     (rasEmpty)
    );

    // State, latched instruction fields, channel counter and sticky flags.
    // In link-register mode full/empty are constant 0, so the flags never set.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            tipo_q  <= '0;
            op_q    <= '0;
            inm_q   <= 1'b0;
            chan_q  <= '0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            chan_q  <= chan_d;
            if (accept) begin
                tipo_q <= tipo;
                op_q   <= op;
                inm_q  <= inm;
            end
            if (rasPush && rasFull) begin
                ovf_q <= 1'b1;
            end
            if (rasPop && rasEmpty) begin
                unf_q <= 1'b1;
            end
        end
    end

    assign ras_overflow  = ovf_q;
    assign ras_underflow = unf_q;

    // Next state and control outputs; everything idles at 0 so controls
    // only appear during their own active cycle.
    always_comb begin
        state_d         = state_q;
        chan_d          = chan_q;
        instr_ready     = 1'b0;
        mem_req         = 1'b0;
        reg_write       = 1'b0;
        alu_src         = 1'b0;
        mem_write       = 1'b0;
        result_src      = 1'b0;
        pc_src          = 1'b0;
        imm_src         = IMM_NONE;
        alu_control     = ALU_ADD;
        chan_sel        = '0;
        pc_return       = '0;
        pc_return_valid = 1'b0;
        rasPush         = 1'b0;
        rasPop          = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                instr_ready = 1'b1;
                chan_d      = '0;
                if (instr_valid) begin
                    unique case (tipo)
                        TIPO_MEM: state_d = ST_MEM;
                        TIPO_BR:  state_d = ST_BRANCH;
                        default:  state_d = ST_EXEC;
                    endcase
                end
            end

            ST_EXEC: begin
                if (tipo_q == TIPO_ALU) begin
                    reg_write   = 1'b1;
                    alu_src     = inm_q;
                    imm_src     = inm_q ? IMM_ALU : IMM_NONE;
                    alu_control = aluControlFor(op_q);
                end
                state_d = ST_IDLE;
            end

            ST_MEM: begin
                mem_req   = 1'b1;
                mem_write = op_q[MEM_STORE_BIT];
                chan_sel  = chan_q;
                if (mem_ack) begin
                    if (!op_q[MEM_STORE_BIT]) begin
                        reg_write  = 1'b1;
                        result_src = 1'b1;
                    end
                    // Single-channel accesses never leave channel 0
                    if (op_q[MEM_ALLCH_BIT] && chan_q != LAST_CH) begin
                        chan_d = chan_q + CH_W'(1);
                    end else begin
                        chan_d  = '0;
                        state_d = ST_IDLE;
                    end
                end
            end

            ST_BRANCH: begin
                unique case (op_q)
                    BR_B: begin
                        pc_src  = 1'b1;
                        imm_src = IMM_BRANCH;
                    end
                    BR_BEQ: begin
                        pc_src  = zero_flag;
                        imm_src = IMM_BRANCH;
                    end
                    BR_BL: begin
                        pc_src  = 1'b1;
                        imm_src = IMM_BRANCH;
                        rasPush = 1'b1;
                    end
                    default: begin
                        pc_src          = 1'b1;
                        rasPop          = 1'b1;
                        pc_return       = rasTop;
                        pc_return_valid = 1'b1;
                    end
                endcase
                state_d = ST_IDLE;
            end

            default: state_d = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_multicycle_control_unit.sv
// ----------------------------------------------------------------------------
// tb_multicycle_control_unit
// Randomised and directed stimulus with a queue-based scoreboard. The
// driver pushes the expected output vector for every busy cycle; a monitor
// pops one entry per busy cycle and checks idle cycles against all-zero
// controls plus the modelled sticky flags.
// Configuration macro: CU_RAS_EN selects the stack model vs link register.
// ----------------------------------------------------------------------------
module tb_multicycle_control_unit;

    localparam int PC_W      = 9;
    localparam int NUM_CH    = 3;
    localparam int RAS_DEPTH = 4;
    localparam int CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            instr_valid;
    logic            instr_ready;
    logic [1:0]      tipo, op;
    logic            inm, zero_flag;
    logic [PC_W-1:0] pc_plus1;
    logic            mem_req, mem_ack;
    logic            reg_write, alu_src, mem_write, result_src, pc_src;
    logic [1:0]      imm_src;
    logic [2:0]      alu_control;
    logic [CH_W-1:0] chan_sel;
    logic [PC_W-1:0] pc_return;
    logic            pc_return_valid, ras_overflow, ras_underflow;

    multicycle_control_unit #(
        .PC_W      (PC_W),
        .NUM_CH    (NUM_CH),
        .RAS_DEPTH (RAS_DEPTH)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .instr_valid     (instr_valid),
        .instr_ready     (instr_ready),
        .tipo            (tipo),
        .op              (op),
        .inm             (inm),
        .zero_flag       (zero_flag),
        .pc_plus1        (pc_plus1),
        .mem_req         (mem_req),
        .mem_ack         (mem_ack),
        .reg_write       (reg_write),
        .alu_src         (alu_src),
        .mem_write       (mem_write),
        .result_src      (result_src),
        .pc_src          (pc_src),
        .imm_src         (imm_src),
        .alu_control     (alu_control),
        .chan_sel        (chan_sel),
        .pc_return       (pc_return),
        .pc_return_valid (pc_return_valid),
        .ras_overflow    (ras_overflow),
        .ras_underflow   (ras_underflow)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic            reg_write;
        logic            alu_src;
        logic            mem_write;
        logic            result_src;
        logic            pc_src;
        logic            mem_req;
        logic            pc_return_valid;
        logic [1:0]      imm_src;
        logic [2:0]      alu_control;
        logic [CH_W-1:0] chan_sel;
        logic [PC_W-1:0] pc_return;
        logic            ovf;
        logic            unf;
    } out_t;

    out_t            expQ[$];
    int              tests    = 0;
    int              failures = 0;
    logic            monEn    = 1'b0;
    logic            expOvf   = 1'b0;
    logic            expUnf   = 1'b0;
    logic [PC_W-1:0] rasModel[$];
    logic [PC_W-1:0] linkModel = '0;

    function automatic out_t sampleDut();
        out_t s;
        s.reg_write       = reg_write;
        s.alu_src         = alu_src;
        s.mem_write       = mem_write;
        s.result_src      = result_src;
        s.pc_src          = pc_src;
        s.mem_req         = mem_req;
        s.pc_return_valid = pc_return_valid;
        s.imm_src         = imm_src;
        s.alu_control     = alu_control;
        s.chan_sel        = chan_sel;
        s.pc_return       = pc_return;
        s.ovf             = ras_overflow;
        s.unf             = ras_underflow;
        return s;
    endfunction

    function automatic out_t baseRec();
        out_t r;
        r     = '0;
        r.ovf = expOvf;
        r.unf = expUnf;
        return r;
    endfunction

    task automatic checkOutput(input string name, input out_t act, input out_t exp);
        tests++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    task automatic checkBit(input string name, input logic act, input logic exp);
        tests++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s at %0t: got %b expected %b", name, $time, act, exp);
        end
    endtask

    // Monitor: one scoreboard entry per busy cycle, zero controls when idle
    initial begin
        out_t act;
        out_t exp;
        forever begin
            @(negedge clk);
            if (monEn) begin
                act = sampleDut();
                if (!instr_ready) begin
                    if (expQ.size() == 0) begin
                        tests++;
                        failures++;
                        $display("[TB] FAIL busy_unexpected at %0t: got %h expected idle", $time, act);
                    end else begin
                        exp = expQ.pop_front();
                        checkOutput("cycle", act, exp);
                    end
                end else begin
                    checkOutput("idle", act, baseRec());
                end
            end
        end
    end

    // Called at posedge+1 with the DUT expected idle
    task automatic applyStimulus(input logic [1:0] t, input logic [1:0] o, input logic im,
                                 input logic z, input logic [PC_W-1:0] pc, input int ackDelay);
        out_t r;
        int   nch;
        int   d;
        logic a;
        logic newOvf;
        logic newUnf;
        newOvf = expOvf;
        newUnf = expUnf;
        checkBit("ready", instr_ready, 1'b1);
        instr_valid = 1'b1;
        tipo        = t;
        op          = o;
        inm         = im;
        zero_flag   = z;
        pc_plus1    = pc;
        r           = baseRec();
        case (t)
            2'b00: begin
                r.reg_write   = 1'b1;
                r.alu_src     = im;
                r.imm_src     = im ? 2'b01 : 2'b00;
                r.alu_control = {1'b0, o};
                expQ.push_back(r);
            end
            2'b11: expQ.push_back(r);
            2'b10: begin
                r.pc_src  = (o != 2'b01) || z;
                r.imm_src = (o != 2'b11) ? 2'b10 : 2'b00;
                if (o == 2'b10) begin
`ifdef CU_RAS_EN
                    rasModel.push_back(pc);
                    if (rasModel.size() > RAS_DEPTH) begin
                        void'(rasModel.pop_front());
                        newOvf = 1'b1;
                    end
`else
                    linkModel = pc;
`endif
                end else if (o == 2'b11) begin
                    r.pc_return_valid = 1'b1;
`ifdef CU_RAS_EN
                    if (rasModel.size() == 0) begin
                        r.pc_return = '0;
                        newUnf      = 1'b1;
                    end else begin
                        r.pc_return = rasModel.pop_back();
                    end
`else
                    r.pc_return = linkModel;
`endif
                end
                expQ.push_back(r);
            end
            default: ;
        endcase
        @(posedge clk); #1;
        instr_valid = 1'b0;
        if (t == 2'b01) begin
            nch = o[1] ? NUM_CH : 1;
            for (int c = 0; c < nch; c++) begin
                d = (ackDelay < 0) ? int'($urandom_range(0, 3)) : ackDelay;
                for (int k = 0; k <= d; k++) begin
                    a              = (k == d);
                    r              = baseRec();
                    r.mem_req      = 1'b1;
                    r.mem_write    = o[0];
                    r.chan_sel     = CH_W'(c);
                    r.reg_write    = a & ~o[0];
                    r.result_src   = a & ~o[0];
                    expQ.push_back(r);
                    mem_ack = a;
                    @(posedge clk); #1;
                end
            end
        end else begin
            // mem_ack outside MEM must have no effect
            mem_ack = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
        end
        expOvf  = newOvf;
        expUnf  = newUnf;
        mem_ack = 1'($urandom_range(0, 1));
    endtask

    task automatic idleGap(input int n);
        for (int i = 0; i < n; i++) begin
            instr_valid = 1'b0;
            tipo        = 2'($urandom);
            op          = 2'($urandom);
            mem_ack     = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
        end
    endtask

    task automatic resetModel();
        expQ.delete();
        rasModel.delete();
        linkModel = '0;
        expOvf    = 1'b0;
        expUnf    = 1'b0;
    endtask

    initial begin
        rst_n       = 1'b0;
        instr_valid = 1'b0;
        tipo        = '0;
        op          = '0;
        inm         = 1'b0;
        zero_flag   = 1'b0;
        pc_plus1    = '0;
        mem_ack     = 1'b0;
        #12;
        checkBit("reset_ready", instr_ready, 1'b1);
        checkOutput("reset_outputs", sampleDut(), baseRec());
        #10;
        rst_n = 1'b1;
        @(posedge clk); #1;
        monEn = 1'b1;

        // ALU add with immediate, then plain sub/and/or
        applyStimulus(2'b00, 2'b00, 1'b1, 1'b0, 9'h000, 0);
        applyStimulus(2'b00, 2'b01, 1'b0, 1'b0, 9'h000, 0);
        applyStimulus(2'b00, 2'b10, 1'b1, 1'b0, 9'h000, 0);
        applyStimulus(2'b00, 2'b11, 1'b0, 1'b0, 9'h000, 0);
        applyStimulus(2'b11, 2'b00, 1'b1, 1'b0, 9'h000, 0);
        // Store all channels with two wait cycles per ack, then loads
        applyStimulus(2'b01, 2'b11, 1'b0, 1'b0, 9'h000, 2);
        applyStimulus(2'b01, 2'b10, 1'b0, 1'b0, 9'h000, 0);
        applyStimulus(2'b01, 2'b00, 1'b0, 1'b0, 9'h000, 1);
        // Nested call/return
        applyStimulus(2'b10, 2'b10, 1'b0, 1'b0, 9'h010, 0);
        applyStimulus(2'b10, 2'b10, 1'b0, 1'b0, 9'h020, 0);
        applyStimulus(2'b10, 2'b11, 1'b0, 1'b0, 9'h1FF, 0);
        applyStimulus(2'b10, 2'b11, 1'b0, 1'b0, 9'h1FF, 0);
        // BEQ not taken / taken, unconditional B
        applyStimulus(2'b10, 2'b01, 1'b0, 1'b0, 9'h000, 0);
        applyStimulus(2'b10, 2'b01, 1'b0, 1'b1, 9'h000, 0);
        applyStimulus(2'b10, 2'b00, 1'b0, 1'b0, 9'h000, 0);
        // Overflow with five calls, underflow with six returns
        for (int i = 1; i <= 5; i++) begin
            applyStimulus(2'b10, 2'b10, 1'b0, 1'b0, PC_W'(9'h100 + i), 0);
        end
        for (int i = 0; i < 6; i++) begin
            applyStimulus(2'b10, 2'b11, 1'b0, 1'b0, 9'h000, 0);
        end

        // Random mix
        for (int i = 0; i < 150; i++) begin
            applyStimulus(2'($urandom), 2'($urandom), 1'($urandom), 1'($urandom),
                          PC_W'($urandom), -1);
            idleGap(int'($urandom_range(0, 2)));
        end

        // Reset while MEM waits for its ack
        monEn = 1'b0;
        #1;
        expQ.delete();
        instr_valid = 1'b1;
        tipo        = 2'b01;
        op          = 2'b00;
        mem_ack     = 1'b0;
        @(posedge clk); #1;
        instr_valid = 1'b0;
        #1;
        checkBit("mem_req_before_reset", mem_req, 1'b1);
        rst_n = 1'b0;
        #1;
        checkBit("reset_mem_req", mem_req, 1'b0);
        checkBit("reset_mid_ready", instr_ready, 1'b1);
        resetModel();
        checkOutput("reset_mid_outputs", sampleDut(), baseRec());
        #4;
        rst_n = 1'b1;
        @(posedge clk); #1;
        mem_ack = 1'b1;
        @(posedge clk); #1;
        mem_ack = 1'b0;
        checkBit("late_ack_ready", instr_ready, 1'b1);
        checkBit("late_ack_reg_write", reg_write, 1'b0);
        monEn = 1'b1;

        for (int i = 0; i < 30; i++) begin
            applyStimulus(2'($urandom), 2'($urandom), 1'($urandom), 1'($urandom),
                          PC_W'($urandom), -1);
        end
        idleGap(3);
        monEn = 1'b0;
        tests++;
        if (expQ.size() != 0) begin
            failures++;
            $display("[TB] FAIL drain: got %0d pending expected 0", expQ.size());
        end

        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule
